counter_run_arbiter: RTL and testbench

Shares one synchronous sequence counter between two requesters. The counter is the JK-flip-flop style block with clear and advance inputs. The arbiter grants the counter round-robin and pulses the counter clear once. It then enables the counter for the requested number of steps and returns a one-cycle done pulse to the winner. It sits between the requesting control logic and the counter's clear/enable pins.

---
 rtl/counter_run_arbiter.sv | 86 ++++++++
 tb/tb_counter_run_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/counter_run_arbiter.sv
// Round-robin arbiter that lends one shared sequence counter to two requesters:
// one clear pulse, then a run of enabled steps, then a done pulse to the owner.
module counter_run_arbiter #(
   parameter int LEN_W = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [1:0]       req,
   input  logic [LEN_W-1:0] len0,
   input  logic [LEN_W-1:0] len1,
   input  logic             pause,
   output logic [1:0]       grant,
   output logic             cnt_clear,
   output logic             cnt_en,
   output logic [1:0]       done,
   output logic             busy,
   output logic [LEN_W-1:0] steps_left
);

   typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic             winner, winner_nxt;
   logic             last, last_nxt;
   logic [LEN_W-1:0] steps_nxt;
   logic [1:0]       owner;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of process ordering.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state      <= IDLE;
         winner     <= 1'b0;
         last       <= 1'b1;
         steps_left <= '0;
      end else begin
         state      <= state_nxt;
         winner     <= winner_nxt;
         last       <= last_nxt;
         steps_left <= steps_nxt;
      end
   end

   // NOTE: every signal driven here gets its hold value first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt  = state;
      winner_nxt = winner;
      last_nxt   = last;
      steps_nxt  = steps_left;
      case (state)
         IDLE: begin
            if (req != 2'b00) begin
               // On a tie the requester that was not served last time wins.
               winner_nxt = (req == 2'b11) ? ~last : req[1];
               steps_nxt  = winner_nxt ? len1 : len0;
               state_nxt  = CLR;
            end
         end
         CLR: begin
            state_nxt = (steps_left == '0) ? DONE : RUN;
         end
         RUN: begin
            if (!pause && (steps_left != '0)) begin
               steps_nxt = steps_left - 1'b1;
               if (steps_left == LEN_W'(1))
                  state_nxt = DONE;
            end
         end
         DONE: begin
            last_nxt  = winner;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decode registered state only; cnt_en alone follows pause directly.
   assign owner     = winner ? 2'b10 : 2'b01;
   assign busy      = (state != IDLE);
   assign grant     = busy ? owner : 2'b00;
   assign cnt_clear = (state == CLR);
   assign cnt_en    = (state == RUN) && !pause;
   assign done      = (state == DONE) ? owner : 2'b00;

endmodule

// File: tb/tb_counter_run_arbiter.sv
// Bench for counter_run_arbiter: table of runs with a per-cycle scoreboard,
// followed by a hand-written asynchronous-clear abort sequence.
module tb_counter_run_arbiter;

   localparam int LEN_W = 4;

   logic             clock;
   logic             clear;
   logic [1:0]       req;
   logic [LEN_W-1:0] len0;
   logic [LEN_W-1:0] len1;
   logic             pause;
   logic [1:0]       grant;
   logic             cnt_clear;
   logic             cnt_en;
   logic [1:0]       done;
   logic             busy;
   logic [LEN_W-1:0] steps_left;

   counter_run_arbiter #(.LEN_W(LEN_W)) dut (
      .clock      (clock),
      .clear      (clear),
      .req        (req),
      .len0       (len0),
      .len1       (len1),
      .pause      (pause),
      .grant      (grant),
      .cnt_clear  (cnt_clear),
      .cnt_en     (cnt_en),
      .done       (done),
      .busy       (busy),
      .steps_left (steps_left)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct packed {
      logic [1:0]       grant;
      logic             clr;
      logic             en;
      logic [1:0]       done;
      logic             busy;
      logic [LEN_W-1:0] steps;
   } obs_t;

   typedef struct {
      logic [1:0]       req;
      logic [1:0]       req_run;
      logic [LEN_W-1:0] len0;
      logic [LEN_W-1:0] len0_run;
      logic [LEN_W-1:0] len1;
      logic [63:0]      pause_mask;
      logic             exp_winner;
      int               exp_en;
      int               exp_done;
   } vec_t;

   int   total = 0;
   int   bad   = 0;
   obs_t sb[$];
   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic obs_t sample();
      return {grant, cnt_clear, cnt_en, done, busy, steps_left};
   endfunction

   task automatic check_invariants(input string tag);
      check({tag, " grant_onehot0"}, 64'($onehot0(grant)), 64'd1);
      check({tag, " done_exclusive"}, 64'((|done) && (cnt_en || cnt_clear)), 64'd0);
   endtask

   // Called at posedge+1 with the DUT in IDLE; leaves at posedge+1 in IDLE.
   task automatic run_vec(input int k, input vec_t v);
      logic [1:0] oh;
      int         s;
      int         i;
      int         ncyc;
      int         en_cnt;
      int         done_at;
      obs_t       e;
      obs_t       got;
      oh = v.exp_winner ? 2'b10 : 2'b01;
      s  = v.exp_winner ? int'(v.len1) : int'(v.len0);
      sb.push_back(obs_t'(0));
      sb.push_back({oh, 1'b1, 1'b0, 2'b00, 1'b1, LEN_W'(s)});
      i = 2;
      while (s > 0) begin
         sb.push_back({oh, 1'b0, ~v.pause_mask[i], 2'b00, 1'b1, LEN_W'(s)});
         if (!v.pause_mask[i]) s--;
         i++;
      end
      sb.push_back({oh, 1'b0, 1'b0, oh, 1'b1, LEN_W'(0)});
      ncyc    = i + 1;
      en_cnt  = 0;
      done_at = -1;
      for (int c = 0; c < ncyc; c++) begin
         req   = (c == 0) ? v.req : v.req_run;
         len0  = (c == 0) ? v.len0 : v.len0_run;
         len1  = v.len1;
         pause = v.pause_mask[c];
         @(negedge clock);
         got = sample();
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL v%0d c%0d scoreboard_empty: got %0h expected entry", k, c, got);
         end else begin
            e = sb.pop_front();
            check($sformatf("v%0d c%0d outputs", k, c), 64'(got), 64'(e));
         end
         check_invariants($sformatf("v%0d c%0d", k, c));
         if (cnt_en) en_cnt++;
         if ((done != 2'b00) && (done_at < 0)) done_at = c;
         @(posedge clock);
         #1;
      end
      check($sformatf("v%0d enable_count", k), 64'(en_cnt), 64'(v.exp_en));
      check($sformatf("v%0d done_cycle", k), 64'(done_at), 64'(v.exp_done));
   endtask

   initial begin
      obs_t got;

      // {req, req_run, len0, len0_run, len1, pause_mask, winner, enables, done cycle}
      vecs[0] = '{2'b11, 2'b11, 4'd2,  4'd2, 4'd1, 64'h0,  1'b0, 2,  4};
      vecs[1] = '{2'b11, 2'b11, 4'd2,  4'd2, 4'd1, 64'h0,  1'b1, 1,  3};
      vecs[2] = '{2'b11, 2'b11, 4'd2,  4'd2, 4'd1, 64'h0,  1'b0, 2,  4};
      vecs[3] = '{2'b01, 2'b00, 4'd3,  4'd3, 4'd1, 64'h0,  1'b0, 3,  5};
      vecs[4] = '{2'b10, 2'b10, 4'd3,  4'd3, 4'd4, 64'h18, 1'b1, 4,  8};
      vecs[5] = '{2'b01, 2'b01, 4'd0,  4'd0, 4'd7, 64'h0,  1'b0, 0,  2};
      vecs[6] = '{2'b11, 2'b01, 4'd5,  4'd5, 4'd2, 64'h0,  1'b1, 2,  4};
      vecs[7] = '{2'b01, 2'b00, 4'd15, 4'd1, 4'd0, 64'h0,  1'b0, 15, 17};

      req   = 2'b00;
      len0  = '0;
      len1  = '0;
      pause = 1'b0;
      clear = 1'b0;
      #1 clear = 1'b1;
      #2;
      check("reset outputs", 64'(sample()), 64'd0);
      #13 clear = 1'b0;

      for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

      // Abort a run with an asynchronous clear while two steps remain.
      req  = 2'b01;
      len0 = 4'd4;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         if (c == 1) check("abort cnt_clear", 64'(cnt_clear), 64'd1);
         if (c == 4) check("abort steps_before", 64'(steps_left), 64'd2);
         if (c < 4) begin
            @(posedge clock);
            #1;
         end
      end
      #2 clear = 1'b1;
      #1;
      check("abort async outputs", 64'(sample()), 64'd0);
      req = 2'b11;
      @(posedge clock);
      #1;
      check("abort held outputs", 64'(sample()), 64'd0);
      #1 clear = 1'b0;
      @(negedge clock);
      check("abort idle after release", 64'(sample()), 64'd0);
      @(posedge clock);
      #1;
      req = 2'b00;
      @(negedge clock);
      got = sample();
      check("post_abort grant", 64'(got.grant), 64'h1);
      check("post_abort cnt_clear", 64'(got.clr), 64'd1);
      check("post_abort steps", 64'(got.steps), 64'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
